// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a dual-digit common-anode 7-segment display.
// Shares one nibble decoder between two digits with dead time and frame-synchronous updates.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high
//   load       - 1-cycle strobe, captures d0/d1 into the pending buffer
//   d0, d1     - new values for digit 0 (right) and digit 1 (left)
//   blank_en   - forces both anodes off; sequencing continues
//   s          - nibble to the 7-segment decoder
//   an         - active-low anode enables, an[0]=digit0, an[1]=digit1
//   frame_done - 1-cycle pulse on the commit cycle (last cycle of BLANK1)
//   pend       - pending values not yet committed
module seven_seg_scan_ctrl #(
  parameter int SHOW_CYCLES  = 12000,
  parameter int BLANK_CYCLES = 48,
  parameter int CNT_W = $clog2((SHOW_CYCLES > BLANK_CYCLES) ?
                               SHOW_CYCLES : BLANK_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic       blank_en,
  output logic [3:0] s,
  output logic [1:0] an,
  output logic       frame_done,
  output logic       pend
);

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             last;
  logic             commit;

  logic [3:0]       act0;
  logic [3:0]       act1;
  logic [3:0]       pnd0;
  logic [3:0]       pnd1;
  logic             pend_q;
  logic             blank_q;

  // Phase sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    last     = 1'b0;
    case (state)
      SHOW0:  last = (cnt == SHOW_LAST);
      BLANK0: last = (cnt == BLANK_LAST);
      SHOW1:  last = (cnt == SHOW_LAST);
      BLANK1: last = (cnt == BLANK_LAST);
      default: last = 1'b1;
    endcase
    if (last) begin
      cnt_nx = '0;
      case (state)
        SHOW0:   state_nx = BLANK0;
        BLANK0:  state_nx = SHOW1;
        SHOW1:   state_nx = BLANK1;
        BLANK1:  state_nx = SHOW0;
        default: state_nx = BLANK1;
      endcase
    end
  end

  assign commit = (state == BLANK1) && (cnt == BLANK_LAST);

  // Double buffer: displayed values only change on the commit cycle,
  // so a frame never shows a mix of old and new digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      act0    <= '0;
      act1    <= '0;
      pnd0    <= '0;
      pnd1    <= '0;
      pend_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      // Registered so blank_en has no combinational path to an
      blank_q <= blank_en;
      if (commit) begin
        pend_q <= 1'b0;
        if (load) begin
          act0 <= d0;
          act1 <= d1;
        end else if (pend_q) begin
          act0 <= pnd0;
          act1 <= pnd1;
        end
      end else if (load) begin
        pnd0   <= d0;
        pnd1   <= d1;
        pend_q <= 1'b1;
      end
    end
  end

  // Blank phases present the upcoming digit so the decoder settles
  // before its anode turns on.
  always_comb begin
    an = 2'b11;
    s  = act0;
    case (state)
      SHOW0: begin
        an = 2'b10;
        s  = act0;
      end
      BLANK0: s = act1;
      SHOW1: begin
        an = 2'b01;
        s  = act1;
      end
      BLANK1: s = act0;
      default: s = act0;
    endcase
    if (blank_q) an = 2'b11;
  end

  assign frame_done = commit;
  assign pend       = pend_q;

endmodule
